// File: rtl/flap_key_conditioner_if.sv
// Push-button conditioner bus: raw key level in, debounced pulse/level out.
interface flap_key_conditioner_if;
   logic key_raw;
   logic press;
   logic held;

   modport master (
      output key_raw,
      input  press,
      input  held
   );

   modport slave (
      input  key_raw,
      output press,
      output held
   );
endinterface

// File: rtl/flap_key_conditioner.sv
// Conditions a raw push-button into a single-cycle press pulse and a debounced
// held level: two-flop synchroniser, then a four-state stability-check FSM.
module flap_key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   flap_key_conditioner_if.slave key_if
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_ZERO = '0;
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic           POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sync1_q, sync1_d;
   logic           sync2_q, sync2_d;
   logic           press_q, press_d;
   logic           held_q, held_d;
   logic           key_n;
   logic           key_sync;

   // Saturating increment so a stuck counter can never wrap back to zero.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v < CNT_MAX) begin
         return v + CNT_ONE;
      end else begin
         return v;
      end
   endfunction

   assign key_n    = key_if.key_raw ^ POL;   // 1 = pressed from here on
   assign key_sync = sync2_q;

   // Synchroniser next values; reset forces both stages to "not pressed".
   always_comb begin
      sync1_d = sync1_q;
      sync2_d = sync2_q;
      if (reset) begin
         sync1_d = 1'b0;
         sync2_d = 1'b0;
      end else begin
         sync1_d = key_n;
         sync2_d = sync1_q;
      end
   end

   // Debounce FSM: next state, stability counter and registered-output inputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (reset) begin
         state_d = RELEASED;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            RELEASED: begin
               if (key_sync) begin
                  state_d = PRESS_CHK;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d   = CNT_ZERO;
               end
            end
            PRESS_CHK: begin
               if (!key_sync) begin
                  state_d = RELEASED;       // bounce: drop without a pulse
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = PRESSED;
                  cnt_d   = CNT_ZERO;
                  press_d = 1'b1;
               end else begin
                  cnt_d   = sat_inc(cnt_q);
               end
            end
            PRESSED: begin
               if (!key_sync) begin
                  state_d = RELEASE_CHK;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d   = cnt_q;
               end
            end
            RELEASE_CHK: begin
               if (key_sync) begin
                  state_d = PRESSED;        // release glitch: no new pulse
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = RELEASED;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d   = sat_inc(cnt_q);
               end
            end
            default: begin
               state_d = RELEASED;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
      held_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
   end

   // All state and outputs register here; reset is folded into the _d logic.
   always_ff @(posedge clk) begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      held_q  <= held_d;
   end

   assign key_if.press = press_q;
   assign key_if.held  = held_q;

endmodule

// File: tb/tb_flap_key_conditioner.sv
// Self-checking bench: two instances (D=4 active-low, D=2 active-high) driven
// from a vector table, hand-written corner sequences and random key traffic,
// every cycle compared against a run-length debounce reference model.
module tb_flap_key_conditioner;

   logic clk = 1'b0;
   logic reset;

   flap_key_conditioner_if if_a ();
   flap_key_conditioner_if if_b ();

   flap_key_conditioner #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut_a (
      .clk    (clk),
      .reset  (reset),
      .key_if (if_a.slave)
   );

   flap_key_conditioner #(.DEBOUNCE_CYCLES(2), .ACTIVE_LOW(0)) dut_b (
      .clk    (clk),
      .reset  (reset),
      .key_if (if_b.slave)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state, index 0 = dut_a, 1 = dut_b.
   int   m_d[2]  = '{4, 2};
   logic m_al[2] = '{1'b1, 1'b0};
   logic m_pipe[2][$];     // synchronised pressed samples, oldest first
   logic m_level[2];       // accepted debounced level
   int   m_run[2];         // consecutive synced samples disagreeing with level
   logic m_press[2];
   logic m_held[2];

   int pulses_a = 0;
   int pulses_b = 0;

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // A level change is accepted once D consecutive synchronised samples
   // disagree with the current level; only a change to pressed pulses.
   task automatic model_edge(input int i, input logic r, input logic raw);
      logic ks;
      if (r) begin
         m_pipe[i]  = '{1'b0, 1'b0};
         m_level[i] = 1'b0;
         m_run[i]   = 0;
         m_press[i] = 1'b0;
      end else begin
         ks = m_pipe[i].pop_front();
         m_pipe[i].push_back(raw ^ m_al[i]);
         m_press[i] = 1'b0;
         if (ks != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == m_d[i]) begin
               m_level[i] = ~m_level[i];
               m_run[i]   = 0;
               m_press[i] = m_level[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_held[i] = m_level[i];
   endtask

   task automatic step(input logic r, input logic ka, input logic kb);
      @(negedge clk);
      reset       = r;
      if_a.key_raw = ka;
      if_b.key_raw = kb;
      @(posedge clk);
      model_edge(0, r, ka);
      model_edge(1, r, kb);
      #1;
      cyc++;
      check("model_press_a", if_a.press, m_press[0]);
      check("model_held_a",  if_a.held,  m_held[0]);
      check("model_press_b", if_b.press, m_press[1]);
      check("model_held_b",  if_b.held,  m_held[1]);
      if (if_a.press === 1'b1) pulses_a++;
      if (if_b.press === 1'b1) pulses_b++;
   endtask

   typedef struct {
      logic rst;
      logic ka;
      logic kb;
      logic ep_a;
      logic eh_a;
      logic ep_b;
      logic eh_b;
   } vec_t;

   vec_t vecs[30];

   initial begin
      int first;
      int held_lo;
      int hi_a, len_a, hi_b, len_b;
      logic r;

      reset        = 1'b1;
      if_a.key_raw = 1'b1;
      if_b.key_raw = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_pipe[i]  = '{1'b0, 1'b0};
         m_level[i] = 1'b0;
         m_run[i]   = 0;
         m_press[i] = 1'b0;
         m_held[i]  = 1'b0;
      end

      // Test 1 table: reset 2, press 20, release 8 (hand-derived expectations).
      for (int i = 0; i < 30; i++) begin
         vecs[i].rst  = (i < 2);
         vecs[i].ka   = (i >= 2 && i < 22) ? 1'b0 : 1'b1;
         vecs[i].kb   = 1'b0;
         vecs[i].ep_a = (i == 7);
         vecs[i].eh_a = (i >= 7 && i < 27);
         vecs[i].ep_b = 1'b0;
         vecs[i].eh_b = 1'b0;
      end
      for (int i = 0; i < 30; i++) begin
         step(vecs[i].rst, vecs[i].ka, vecs[i].kb);
         check("tbl_press_a", if_a.press, vecs[i].ep_a);
         check("tbl_held_a",  if_a.held,  vecs[i].eh_a);
         check("tbl_press_b", if_b.press, vecs[i].ep_b);
         check("tbl_held_b",  if_b.held,  vecs[i].eh_b);
      end

      // Test 2: bounce is filtered entirely.
      pulses_a = 0;
      held_lo  = 0;
      for (int i = 0; i < 3; i++)  begin step(1'b0, 1'b0, 1'b0); held_lo += int'(if_a.held); end
      for (int i = 0; i < 2; i++)  begin step(1'b0, 1'b1, 1'b0); held_lo += int'(if_a.held); end
      for (int i = 0; i < 2; i++)  begin step(1'b0, 1'b0, 1'b0); held_lo += int'(if_a.held); end
      for (int i = 0; i < 10; i++) begin step(1'b0, 1'b1, 1'b0); held_lo += int'(if_a.held); end
      check_int("bounce_pulses", pulses_a, 0);
      check_int("bounce_held_cycles", held_lo, 0);

      // Test 3: release glitch keeps held, no second pulse; then full release.
      pulses_a = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
      check("glitch_held_before", if_a.held, 1'b1);
      held_lo = 0;
      for (int i = 0; i < 2; i++)  begin step(1'b0, 1'b1, 1'b0); held_lo += int'(!if_a.held); end
      for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0, 1'b0); held_lo += int'(!if_a.held); end
      check_int("glitch_held_drop", held_lo, 0);
      first = 0;
      for (int n = 1; n <= 8; n++) begin
         step(1'b0, 1'b1, 1'b0);
         if (if_a.held === 1'b0 && first == 0) first = n;
      end
      check_int("release_latency", first, 6);
      check_int("glitch_pulses", pulses_a, 1);

      // Test 4: two clean presses of 8 separated by 8 released.
      pulses_a = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
         for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
      end
      check_int("two_presses", pulses_a, 2);

      // Test 5: reset in the middle of a hold re-arms the press.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("reset_press_low", if_a.press, 1'b0);
      check("reset_held_low",  if_a.held,  1'b0);
      pulses_a = 0;
      first    = 0;
      for (int n = 1; n <= 12; n++) begin
         step(1'b0, 1'b0, 1'b0);
         if (n == 5) check("rearm_held_pre", if_a.held, 1'b0);
         if (n == 6) check("rearm_held_at",  if_a.held, 1'b1);
         if (if_a.press === 1'b1 && first == 0) first = n;
      end
      check_int("rearm_latency", first, 6);
      check_int("rearm_pulses", pulses_a, 1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);

      // Test 6: active-high instance with D=2.
      pulses_b = 0;
      first    = 0;
      for (int n = 1; n <= 10; n++) begin
         step(1'b0, 1'b1, 1'b1);
         if (if_b.press === 1'b1 && first == 0) first = n;
      end
      check_int("ah_latency", first, 4);
      check_int("ah_pulses", pulses_b, 1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
      check("ah_released", if_b.held, 1'b0);

      // Random key traffic with burst lengths spanning both sides of the filter.
      hi_a = 0; len_a = 0; hi_b = 0; len_b = 0;
      for (int i = 0; i < 3000; i++) begin
         if (len_a == 0) begin hi_a = 1 - hi_a; len_a = int'($urandom_range(1, 12)); end
         if (len_b == 0) begin hi_b = 1 - hi_b; len_b = int'($urandom_range(1, 8)); end
         len_a--;
         len_b--;
         r = ($urandom_range(0, 199) == 0);
         step(r, hi_a[0], hi_b[0]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
